uart_rx_oversample: RTL and testbench
=====================================

# uart_rx_oversample

Standalone 8N1 UART receiver: recovers bytes from an asynchronous serial line and holds them behind a valid/ready handshake. It is the receive end for frames produced by the team's UART transmit path and can be dropped into any top level in place of the combined rx/tx core when only reception is needed. Noise rejection comes from a two-flop input synchronizer, start-bit validation, and a 3-sample majority vote taken at each bit centre. Framing and overrun errors are flagged.

## Interface
- BAUD_RATE, 24'd4000000: serial bit rate in bits/s.
- CLOCK_FREQ, 28'd100000000: clk_int frequency in Hz.
- CLKS_PER_BIT (localparam) = CLOCK_FREQ / BAUD_RATE, using integer division. It must be ≥ 4; elaboration fails otherwise.
- HALF (localparam) = CLKS_PER_BIT / 2.

Ports:
- clk_int, input, 1: the single clock.
- uart_reset, input, 1: reset, asynchronous and active-low.
- uart_rx_d_in, input, 1: serial line. Asynchronous; idles high.
- rx_ready, input, 1: consumer accepts rx_data this cycle.
- rx_data, output, 8: received byte, LSB first on the wire.
- rx_valid, output, 1: rx_data holds an unconsumed byte.
- rx_frame_err, output, 1: one-cycle pulse when a stop bit is sampled as 0.
- rx_overrun, output, 1: one-cycle pulse when a completed byte is dropped.

## Operation
- Synchronizer: two flops, both resetting to 1. Call the second flop's output `s`; `s_d` is `s` delayed by one cycle.
- Bit counter `cnt`: counts 0..CLKS_PER_BIT-1. It is cleared on every state entry and at the end of every bit.
- Bit index `idx`: 0..7.
- Majority vote: `s` is captured at cnt = HALF-1, HALF and HALF+1. The bit value is decided at cnt = HALF+1 as the majority of the three samples.

FSM states:
- IDLE: on s_d=1 and s=0 (a falling edge), go to START with cnt←0. A line held low never re-triggers, because an edge is required.
- START: at the decision point, a vote of 1 is a false start and returns to IDLE. A vote of 0 stays in START until cnt = CLKS_PER_BIT-1, then goes to DATA with idx←0.
- DATA: at the decision point, shift_reg[idx] ← vote. At cnt = CLKS_PER_BIT-1, go to STOP if idx = 7; otherwise idx←idx+1.
- STOP: at the decision point:
  - vote 1: the frame completes and the FSM goes to IDLE immediately, without waiting out the stop bit.
  - vote 0: rx_frame_err pulses, no data is delivered, and the FSM goes to IDLE.

Output holding register, evaluated on frame completion:
- rx_valid=0, or rx_valid=1 with rx_ready=1: rx_data←shift_reg and rx_valid←1.
- rx_valid=1 with rx_ready=0: rx_overrun pulses, and rx_data and rx_valid are unchanged.

Handshake without a completion: rx_valid=1 with rx_ready=1 clears rx_valid.

## Timing
- Reset values: rx_data=0, rx_valid=0, rx_frame_err=0, rx_overrun=0, state=IDLE, cnt=0, idx=0, synchronizer flops=1.
- Edge-detect latency: the FSM enters START 3 cycles after the line falls (2 synchronizer cycles plus the edge register).
- Frame latency: rx_valid and the error/overrun pulses are registered and rise 1 cycle after the STOP decision. From the line's falling edge that is 3 + 9·CLKS_PER_BIT + HALF + 2 cycles, which is 242 cycles at the default parameters.
- Back-to-back frames: a falling edge arriving in the first cycle after the STOP decision must be caught. IDLE is active on that cycle.
- Reset mid-frame: asynchronous return to reset values. A partial byte is discarded.
- rx_ready is ignored while rx_valid=0.

## Structure
- Shared package uart_pkg holds:
  - the 2-bit state encoding (IDLE, START, DATA, STOP);
  - a constant function computing CLKS_PER_BIT;
  - the 8N1 frame constants (8 data bits, 1 stop bit).
- One sub-module, uart_bit_sync: the two-flop synchronizer with a reset value of 1, reusable by the transmit path's inputs.

## Test plan
All scenarios use the defaults: CLKS_PER_BIT=25 and HALF=12.
1. Send 0xA5 at 4 Mbaud, rx_ready=1 → rx_valid high for exactly 1 cycle, rx_data=0xA5, no error pulses.
2. Drive a 5-clock low glitch on an idle line → no rx_valid and no error. The FSM is back in IDLE before cnt reaches 14.
3. Send 0x3C with stop bit 0, hold the line low 50 clocks, release, then send 0x81 → one rx_frame_err pulse with no valid for the first frame. Then rx_valid with rx_data=0x81.
4. Send 0x11 then 0x22 back-to-back with rx_ready=0 → after the second frame, one rx_overrun pulse and rx_data stays 0x11. Raising rx_ready then clears rx_valid.
5. Send 0x00 with a 1-clock high glitch at the centre of bit 3 → majority rejects the glitch and rx_data=0x00.
6. Assert uart_reset during bit 4 of 0xFF, release, then send 0x5A → all outputs are 0 during reset. No valid for the aborted frame, then rx_data=0x5A.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, 8N1 frame constants and the
// bit-period helper used by both the receive and transmit paths.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   localparam int UART_DATA_BITS = 8;
   localparam int UART_STOP_BITS = 1;

   // Integer clocks per serial bit; the remainder is dropped.
   function automatic int clks_per_bit(input logic [31:0] clock_freq,
                                       input logic [31:0] baud_rate);
      return int'(clock_freq / baud_rate);
   endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchronizer for an asynchronous input; both flops reset to 1 so an
// idle UART line does not look like a start bit coming out of reset.
module uart_bit_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver with start-bit validation, 3-sample majority vote at each
// bit centre, framing/overrun flags and a valid/ready output holding register.
module uart_rx_oversample
   import uart_pkg::*;
#(
   parameter logic [23:0] BAUD_RATE  = 24'd4000000,
   parameter logic [27:0] CLOCK_FREQ = 28'd100000000
) (
   input  logic       clk_int,
   input  logic       uart_reset,
   input  logic       uart_rx_d_in,
   input  logic       rx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_frame_err,
   output logic       rx_overrun
);

   localparam int CLKS_PER_BIT = clks_per_bit({4'd0, CLOCK_FREQ}, {8'd0, BAUD_RATE});
   localparam int HALF         = CLKS_PER_BIT / 2;
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] SAMP_A   = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] SAMP_B   = CNT_W'(HALF);
   localparam logic [CNT_W-1:0] DECIDE   = CNT_W'(HALF + 1);
   localparam logic [2:0]       LAST_IDX = 3'(UART_DATA_BITS - 1);

   if (CLKS_PER_BIT < 4) begin : g_bad_ratio
      $error("uart_rx_oversample: CLOCK_FREQ / BAUD_RATE must be at least 4");
   end

   logic                      s;
   logic                      s_d;
   uart_state_t               state;
   logic [CNT_W-1:0]          cnt;
   logic [2:0]                idx;
   logic                      samp_a;
   logic                      samp_b;
   logic                      vote;
   logic                      at_decide;
   logic                      at_last;
   logic [UART_DATA_BITS-1:0] shift_reg;

   uart_bit_sync u_sync (
      .clk   (clk_int),
      .rst_n (uart_reset),
      .d     (uart_rx_d_in),
      .q     (s)
   );

   // The third vote sample is the live synchronized value at the decision point.
   assign vote      = (samp_a & samp_b) | (samp_a & s) | (samp_b & s);
   assign at_decide = (cnt == DECIDE);
   assign at_last   = (cnt == CNT_LAST);

   always_ff @(posedge clk_int or negedge uart_reset) begin
      if (!uart_reset) begin
         s_d          <= 1'b1;
         state        <= IDLE;
         cnt          <= '0;
         idx          <= '0;
         samp_a       <= 1'b1;
         samp_b       <= 1'b1;
         shift_reg    <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
         rx_overrun   <= 1'b0;
      end else begin
         s_d          <= s;
         rx_frame_err <= 1'b0;
         rx_overrun   <= 1'b0;

         if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end

         if (cnt == SAMP_A) begin
            samp_a <= s;
         end
         if (cnt == SAMP_B) begin
            samp_b <= s;
         end

         case (state)
            IDLE: begin
               cnt <= '0;
               if (s_d && !s) begin
                  state <= START;
               end
            end

            START: begin
               if (at_decide && vote) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (at_last) begin
                  state <= DATA;
                  cnt   <= '0;
                  idx   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            DATA: begin
               if (at_decide) begin
                  shift_reg[idx] <= vote;
               end
               if (at_last) begin
                  cnt <= '0;
                  if (idx == LAST_IDX) begin
                     state <= STOP;
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            STOP: begin
               // Return to IDLE at the decision point so a start bit can follow
               // a shortened stop bit.
               if (at_decide) begin
                  state <= IDLE;
                  cnt   <= '0;
                  if (!vote) begin
                     rx_frame_err <= 1'b1;
                  end else if (!rx_valid || rx_ready) begin
                     rx_data  <= shift_reg;
                     rx_valid <= 1'b1;
                  end else begin
                     rx_overrun <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Self-checking bench for uart_rx_oversample: serial frames are generated at
// the line level and received bytes/pulses are compared with a frame-level model.
module tb_uart_rx_oversample;

   localparam int BIT_CLKS    = 25;
   localparam int FRAME_LATENCY = 242;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       line;
   logic       ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;
   logic       rx_overrun;

   int checks   = 0;
   int failures = 0;
   int cycle_cnt = 0;

   logic [7:0] got_q[$];
   int         got_cyc_q[$];
   int         ferr_cyc_q[$];
   int         valid_cycles = 0;
   int         ferr_cnt = 0;
   int         ovr_cnt = 0;
   logic       prev_valid = 1'b0;
   logic       prev_hs = 1'b0;

   uart_rx_oversample dut (
      .clk_int      (clk),
      .uart_reset   (rst_n),
      .uart_rx_d_in (line),
      .rx_ready     (ready),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_frame_err (rx_frame_err),
      .rx_overrun   (rx_overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   // A byte is newly presented when valid rises or stays up right after a handshake.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_valid = 1'b0;
         prev_hs    = 1'b0;
      end else begin
         if (rx_valid && (!prev_valid || prev_hs)) begin
            got_q.push_back(rx_data);
            got_cyc_q.push_back(cycle_cnt);
         end
         if (rx_valid) valid_cycles++;
         if (rx_frame_err) begin
            ferr_cnt++;
            ferr_cyc_q.push_back(cycle_cnt);
         end
         if (rx_overrun) ovr_cnt++;
         prev_valid = rx_valid;
         prev_hs    = rx_valid && ready;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hold(input logic v, input int n);
      line = v;
      repeat (n) tick();
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_val,
                             input int stop_len, output int fall_cyc);
      fall_cyc = cycle_cnt;
      hold(1'b0, BIT_CLKS);
      for (int i = 0; i < 8; i++) hold(b[i], BIT_CLKS);
      hold(stop_val, stop_len);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      line  = 1'b1;
      ready = 1'b0;
      repeat (3) tick();
      checks++; if (rx_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_data got=%h want=00", rx_data); end
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b want=0", rx_valid); end
      checks++; if (rx_frame_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_ferr got=%b want=0", rx_frame_err); end
      checks++; if (rx_overrun !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovr got=%b want=0", rx_overrun); end
      rst_n = 1'b1;
      hold(1'b1, 10);
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL idle_valid got=%b want=0", rx_valid); end
   endtask

   task automatic test_single_byte();
      int base_got = got_q.size();
      int base_vc = valid_cycles, base_fe = ferr_cnt, base_ov = ovr_cnt;
      int fall;
      ready = 1'b1;
      send_frame(8'hA5, 1'b1, BIT_CLKS, fall);
      hold(1'b1, 20);
      checks++; if (got_q.size() - base_got !== 1) begin failures++; $display("[TB] FAIL a5_count got=%0d want=1", got_q.size() - base_got); end
      if (got_q.size() > base_got) begin
         checks++; if (got_q[base_got] !== 8'hA5) begin failures++; $display("[TB] FAIL a5_data got=%h want=a5", got_q[base_got]); end
         checks++; if (got_cyc_q[base_got] - fall !== FRAME_LATENCY) begin failures++; $display("[TB] FAIL a5_latency got=%0d want=%0d", got_cyc_q[base_got] - fall, FRAME_LATENCY); end
      end
      checks++; if (valid_cycles - base_vc !== 1) begin failures++; $display("[TB] FAIL a5_valid_width got=%0d want=1", valid_cycles - base_vc); end
      checks++; if (ferr_cnt - base_fe !== 0) begin failures++; $display("[TB] FAIL a5_ferr got=%0d want=0", ferr_cnt - base_fe); end
      checks++; if (ovr_cnt - base_ov !== 0) begin failures++; $display("[TB] FAIL a5_ovr got=%0d want=0", ovr_cnt - base_ov); end
   endtask

   task automatic test_glitch();
      int base_got = got_q.size();
      int base_fe = ferr_cnt;
      int fall;
      logic [7:0] b = 8'($urandom);
      hold(1'b0, 5);
      hold(1'b1, 60);
      checks++; if (got_q.size() - base_got !== 0) begin failures++; $display("[TB] FAIL glitch_valid got=%0d want=0", got_q.size() - base_got); end
      checks++; if (ferr_cnt - base_fe !== 0) begin failures++; $display("[TB] FAIL glitch_ferr got=%0d want=0", ferr_cnt - base_fe); end
      // A real start 16 clocks after the glitch is only caught if the false start was abandoned early.
      hold(1'b0, 5);
      hold(1'b1, 11);
      send_frame(b, 1'b1, BIT_CLKS, fall);
      hold(1'b1, 20);
      checks++; if (got_q.size() - base_got !== 1) begin failures++; $display("[TB] FAIL glitch_then_frame_count got=%0d want=1", got_q.size() - base_got); end
      if (got_q.size() > base_got) begin
         checks++; if (got_q[base_got] !== b) begin failures++; $display("[TB] FAIL glitch_then_frame_data got=%h want=%h", got_q[base_got], b); end
         checks++; if (got_cyc_q[base_got] - fall !== FRAME_LATENCY) begin failures++; $display("[TB] FAIL glitch_then_frame_latency got=%0d want=%0d", got_cyc_q[base_got] - fall, FRAME_LATENCY); end
      end
      checks++; if (ferr_cnt - base_fe !== 0) begin failures++; $display("[TB] FAIL glitch_then_frame_ferr got=%0d want=0", ferr_cnt - base_fe); end
   endtask

   task automatic test_frame_error();
      int base_got = got_q.size();
      int base_fe = ferr_cnt, base_ov = ovr_cnt, base_fc = ferr_cyc_q.size();
      int fall, fall2;
      send_frame(8'h3C, 1'b0, BIT_CLKS, fall);
      hold(1'b0, 50);
      hold(1'b1, 10);
      checks++; if (ferr_cnt - base_fe !== 1) begin failures++; $display("[TB] FAIL ferr_count got=%0d want=1", ferr_cnt - base_fe); end
      if (ferr_cyc_q.size() > base_fc) begin
         checks++; if (ferr_cyc_q[base_fc] - fall !== FRAME_LATENCY) begin failures++; $display("[TB] FAIL ferr_latency got=%0d want=%0d", ferr_cyc_q[base_fc] - fall, FRAME_LATENCY); end
      end
      checks++; if (got_q.size() - base_got !== 0) begin failures++; $display("[TB] FAIL ferr_no_valid got=%0d want=0", got_q.size() - base_got); end
      send_frame(8'h81, 1'b1, BIT_CLKS, fall2);
      hold(1'b1, 20);
      checks++; if (got_q.size() - base_got !== 1) begin failures++; $display("[TB] FAIL after_ferr_count got=%0d want=1", got_q.size() - base_got); end
      if (got_q.size() > base_got) begin
         checks++; if (got_q[base_got] !== 8'h81) begin failures++; $display("[TB] FAIL after_ferr_data got=%h want=81", got_q[base_got]); end
      end
      checks++; if (ferr_cnt - base_fe !== 1) begin failures++; $display("[TB] FAIL after_ferr_ferr got=%0d want=1", ferr_cnt - base_fe); end
      checks++; if (ovr_cnt - base_ov !== 0) begin failures++; $display("[TB] FAIL after_ferr_ovr got=%0d want=0", ovr_cnt - base_ov); end
   endtask

   task automatic test_back_to_back();
      int base_got = got_q.size();
      int base_ov = ovr_cnt, base_fe = ferr_cnt;
      int fall;
      ready = 1'b0;
      // Stop bit trimmed to 15 clocks: the next start edge reaches the FSM on its first IDLE cycle.
      send_frame(8'h11, 1'b1, 15, fall);
      send_frame(8'h22, 1'b1, BIT_CLKS, fall);
      hold(1'b1, 20);
      checks++; if (ovr_cnt - base_ov !== 1) begin failures++; $display("[TB] FAIL b2b_overrun got=%0d want=1", ovr_cnt - base_ov); end
      checks++; if (got_q.size() - base_got !== 1) begin failures++; $display("[TB] FAIL b2b_presented got=%0d want=1", got_q.size() - base_got); end
      checks++; if (rx_data !== 8'h11) begin failures++; $display("[TB] FAIL b2b_data got=%h want=11", rx_data); end
      checks++; if (rx_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_valid_held got=%b want=1", rx_valid); end
      checks++; if (ferr_cnt - base_fe !== 0) begin failures++; $display("[TB] FAIL b2b_ferr got=%0d want=0", ferr_cnt - base_fe); end
      ready = 1'b1;
      tick();
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_drain got=%b want=0", rx_valid); end
      hold(1'b1, 5);
   endtask

   task automatic test_majority();
      int base_got = got_q.size();
      hold(1'b0, BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin
            hold(1'b0, 13);
            hold(1'b1, 1);
            hold(1'b0, 11);
         end else begin
            hold(1'b0, BIT_CLKS);
         end
      end
      hold(1'b1, BIT_CLKS);
      hold(1'b1, 10);
      checks++; if (got_q.size() - base_got !== 1) begin failures++; $display("[TB] FAIL majority_count got=%0d want=1", got_q.size() - base_got); end
      if (got_q.size() > base_got) begin
         checks++; if (got_q[base_got] !== 8'h00) begin failures++; $display("[TB] FAIL majority_data got=%h want=00", got_q[base_got]); end
      end
   endtask

   task automatic test_reset_mid_frame();
      int base_got;
      int base_fe, base_ov;
      int fall;
      ready = 1'b0;
      send_frame(8'hC3, 1'b1, BIT_CLKS, fall);
      hold(1'b1, 10);
      checks++; if (rx_valid !== 1'b1) begin failures++; $display("[TB] FAIL prereset_valid got=%b want=1", rx_valid); end
      hold(1'b0, BIT_CLKS);
      for (int i = 0; i < 4; i++) hold(1'b1, BIT_CLKS);
      hold(1'b1, 10);
      rst_n = 1'b0;
      #1;
      checks++; if (rx_data !== 8'h00) begin failures++; $display("[TB] FAIL midreset_data got=%h want=00", rx_data); end
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL midreset_valid got=%b want=0", rx_valid); end
      checks++; if (rx_frame_err !== 1'b0) begin failures++; $display("[TB] FAIL midreset_ferr got=%b want=0", rx_frame_err); end
      checks++; if (rx_overrun !== 1'b0) begin failures++; $display("[TB] FAIL midreset_ovr got=%b want=0", rx_overrun); end
      hold(1'b1, 4);
      rst_n = 1'b1;
      ready = 1'b1;
      base_got = got_q.size();
      base_fe  = ferr_cnt;
      base_ov  = ovr_cnt;
      hold(1'b1, 150);
      checks++; if (got_q.size() - base_got !== 0) begin failures++; $display("[TB] FAIL aborted_valid got=%0d want=0", got_q.size() - base_got); end
      send_frame(8'h5A, 1'b1, BIT_CLKS, fall);
      hold(1'b1, 20);
      checks++; if (got_q.size() - base_got !== 1) begin failures++; $display("[TB] FAIL postreset_count got=%0d want=1", got_q.size() - base_got); end
      if (got_q.size() > base_got) begin
         checks++; if (got_q[base_got] !== 8'h5A) begin failures++; $display("[TB] FAIL postreset_data got=%h want=5a", got_q[base_got]); end
      end
      checks++; if (ferr_cnt - base_fe !== 0 || ovr_cnt - base_ov !== 0) begin failures++; $display("[TB] FAIL postreset_errs got=%0d/%0d want=0/0", ferr_cnt - base_fe, ovr_cnt - base_ov); end
   endtask

   // Frame-level model: good stop bits deliver their byte in order, bad ones add a framing error.
   task automatic test_random();
      logic [7:0] exp_q[$];
      int exp_ferr = 0;
      int base_got = got_q.size();
      int base_vc = valid_cycles, base_fe = ferr_cnt, base_ov = ovr_cnt;
      int fall;
      ready = 1'b1;
      for (int n = 0; n < 14; n++) begin
         logic [7:0] b = 8'($urandom);
         if ($urandom_range(0, 4) != 0) begin
            send_frame(b, 1'b1, int'($urandom_range(15, 25)), fall);
            exp_q.push_back(b);
            hold(1'b1, int'($urandom_range(0, 20)));
         end else begin
            send_frame(b, 1'b0, BIT_CLKS + int'($urandom_range(0, 30)), fall);
            exp_ferr++;
            hold(1'b1, int'($urandom_range(1, 20)));
         end
      end
      hold(1'b1, 30);
      checks++; if (got_q.size() - base_got !== exp_q.size()) begin failures++; $display("[TB] FAIL rand_count got=%0d want=%0d", got_q.size() - base_got, exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         if (base_got + i < got_q.size()) begin
            checks++;
            if (got_q[base_got + i] !== exp_q[i]) begin
               failures++;
               $display("[TB] FAIL rand_data[%0d] got=%h want=%h", i, got_q[base_got + i], exp_q[i]);
            end
         end
      end
      checks++; if (ferr_cnt - base_fe !== exp_ferr) begin failures++; $display("[TB] FAIL rand_ferr got=%0d want=%0d", ferr_cnt - base_fe, exp_ferr); end
      checks++; if (ovr_cnt - base_ov !== 0) begin failures++; $display("[TB] FAIL rand_ovr got=%0d want=0", ovr_cnt - base_ov); end
      checks++; if (valid_cycles - base_vc !== exp_q.size()) begin failures++; $display("[TB] FAIL rand_valid_cycles got=%0d want=%0d", valid_cycles - base_vc, exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_glitch();
      test_frame_error();
      test_back_to_back();
      test_majority();
      test_reset_mid_frame();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
